// File: rtl/gf2m_mul_seq.sv
// rtl/gf2m_mul_seq.sv - digit-serial GF(2^M) multiplier with trinomial reduction
//
// Computes result = (a * b) mod (x^M + x^K + 1), consuming D bits of b per
// cycle, most-significant digit first (Horner). Latency is NDIG = ceil(M/D)
// cycles from the accepting edge to out_valid.
//
// Optional build macro: GF2M_MUL_ACC_EN adds the acc input. When acc is
// sampled high at acceptance, the new product is XORed into the previously
// held result instead of replacing it.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands a/b present
//   in_ready   block idle and able to accept operands
//   a, b       M-bit operands, bit i = coefficient of x^i
//   acc        accumulate request (GF2M_MUL_ACC_EN builds only)
//   out_valid  result present
//   out_ready  consumer accepts result
//   result     fully reduced product, degree < M

module gf2m_mul_seq #(
    parameter int M = 233,
    parameter int K = 74,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
`ifdef GF2M_MUL_ACC_EN
    input  logic         acc,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] result
);

    localparam int NDIG = (M + D - 1) / D;
    localparam int BW   = NDIG * D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state;
    logic [M-1:0]   a_reg;
    logic [BW-1:0]  b_reg;
    logic [M-1:0]   acc_reg;
    logic [M-1:0]   res_reg;
    logic [CW-1:0]  cnt;
    logic [D-1:0]   digit;
    logic [M+D-1:0] unred;
    logic [M-1:0]   acc_next;
`ifdef GF2M_MUL_ACC_EN
    logic           acc_mode;
`endif

    // b_reg shifts left each RUN cycle, so the digit in use is always on top.
    assign digit = b_reg[BW-1 -: D];

    // One Horner step: acc*x^D xor a*digit, then fold the D overflow bits.
    // x^(M+j) = x^(j+K) + x^j; K + D <= M keeps every fold below degree M,
    // so a single pass fully reduces.
    always_comb begin
        unred = {acc_reg, {D{1'b0}}};
        for (int i = 0; i < D; i++) begin
            if (digit[i]) begin
                unred = unred ^ ({{D{1'b0}}, a_reg} << i);
            end
        end
        acc_next = unred[M-1:0];
        for (int j = 0; j < D; j++) begin
            if (unred[M+j]) begin
                acc_next[j]   = ~acc_next[j];
                acc_next[j+K] = ~acc_next[j+K];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            acc_reg  <= '0;
            res_reg  <= '0;
            cnt      <= '0;
`ifdef GF2M_MUL_ACC_EN
            acc_mode <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= BW'(b);
                        acc_reg  <= '0;
                        cnt      <= CW'(NDIG - 1);
`ifdef GF2M_MUL_ACC_EN
                        acc_mode <= acc;
`endif
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_reg <= acc_next;
                    b_reg   <= b_reg << D;
                    if (cnt == '0) begin
                        state <= S_DONE;
`ifdef GF2M_MUL_ACC_EN
                        res_reg <= acc_mode ? (acc_next ^ res_reg) : acc_next;
`else
                        res_reg <= acc_next;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign result    = res_reg;

endmodule

// File: tb/tb_gf2m_mul_seq.sv
// tb/tb_gf2m_mul_seq.sv - self-checking bench for gf2m_mul_seq
module tb_gf2m_mul_seq;

    localparam int M = 233, K = 74, D = 8, NDIG = 30;
    localparam int SM = 7, SK = 3, SD = 1, SNDIG = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [M-1:0] a, b, result;
    logic s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [SM-1:0] s_a, s_b, s_result;
`ifdef GF2M_MUL_ACC_EN
    logic acc, s_acc;
`endif

    int n_cmp = 0;
    int n_err = 0;

    gf2m_mul_seq #(.M(M), .K(K), .D(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
`ifdef GF2M_MUL_ACC_EN
        .acc(acc),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    gf2m_mul_seq #(.M(SM), .K(SK), .D(SD)) dut_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b),
`ifdef GF2M_MUL_ACC_EN
        .acc(s_acc),
`endif
        .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result)
    );

    // Reference: full schoolbook carry-less product, then reduce from the top
    // degree down using x^d = x^(d-m+k) + x^(d-m).
    function automatic logic [232:0] gf_ref(input logic [232:0] x, input logic [232:0] y,
                                            input int m, input int k);
        logic [465:0] p;
        p = '0;
        for (int i = 0; i < m; i++)
            if (y[i]) p = p ^ (466'(x) << i);
        for (int d = 2*m - 2; d >= m; d--) begin
            if (p[d]) begin
                p[d]       = 1'b0;
                p[d-m]     = ~p[d-m];
                p[d-m+k]   = ~p[d-m+k];
            end
        end
        return p[232:0];
    endfunction

    function automatic logic [M-1:0] rand_m();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
        return t[M-1:0];
    endfunction

    task automatic start_op(input logic [M-1:0] ia, input logic [M-1:0] ib);
        int guard;
        a = ia; b = ib; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 1000) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic run_big(input logic [M-1:0] ia, input logic [M-1:0] ib,
                           output logic [M-1:0] res, output int lat);
        start_op(ia, ib);
        wait_done(lat);
        res = result;
        @(posedge clk); #1;
    endtask

    task automatic run_small(input logic [SM-1:0] ia, input logic [SM-1:0] ib,
                             output logic [SM-1:0] res, output int lat);
        int guard;
        s_a = ia; s_b = ib; s_in_valid = 1'b1;
        guard = 0;
        while (!s_in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        res = s_result;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (result !== '0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [M-1:0] r;
        int lat;
        run_big(M'(1), M'(1), r, lat);
        n_cmp++; if (r !== M'(1)) begin n_err++; $display("FAIL one_times_one got %h want 1", r); end
        n_cmp++; if (lat !== NDIG) begin n_err++; $display("FAIL latency got %0d want %0d", lat, NDIG); end
    endtask

    task automatic test_fold();
        logic [M-1:0] r, ia, exp;
        int lat;
        ia = '0; ia[232] = 1'b1;
        exp = '0; exp[74] = 1'b1; exp[0] = 1'b1;
        run_big(ia, M'(2), r, lat);
        n_cmp++; if (r !== exp) begin n_err++; $display("FAIL fold_x232_x got %h want %h", r, exp); end
    endtask

    task automatic test_zero_ignore();
        int lat, extra;
        start_op('0, '1);
        repeat (5) @(posedge clk);
        #1;
        a = M'(1); b = M'(1); in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 7;
        while (!out_valid && lat < 1000) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat !== NDIG) begin n_err++; $display("FAIL zero_latency got %0d want %0d", lat, NDIG); end
        n_cmp++; if (result !== '0) begin n_err++; $display("FAIL zero_result got %h want 0", result); end
        @(posedge clk); #1;
        extra = 0;
        for (int i = 0; i < NDIG + 10; i++) begin
            if (out_valid) extra++;
            @(posedge clk); #1;
        end
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL ignored_in_valid got %0d extra valid cycles want 0", extra); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_after_ignore got in_ready %b want 1", in_ready); end
    endtask

    task automatic test_backpressure();
        logic [M-1:0] ia, ib, r0;
        int lat, bad;
        ia = rand_m(); ib = rand_m();
        out_ready = 1'b0;
        start_op(ia, ib);
        wait_done(lat);
        r0 = result;
        n_cmp++; if (r0 !== gf_ref(ia, ib, M, K)) begin n_err++; $display("FAIL bp_result got %h want %h", r0, gf_ref(ia, ib, M, K)); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || result !== r0 || in_ready !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL bp_release got ready/valid %b want 10", {in_ready, out_valid}); end
    endtask

    task automatic test_abort();
        logic [M-1:0] r;
        int lat;
        start_op(rand_m(), rand_m());
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL abort_state got ready/valid %b want 10", {in_ready, out_valid}); end
        n_cmp++; if (result !== '0) begin n_err++; $display("FAIL abort_result got %h want 0", result); end
        run_big(M'(1), M'(1), r, lat);
        n_cmp++; if (r !== M'(1) || lat !== NDIG) begin n_err++; $display("FAIL after_abort got %h lat %0d want 1 lat %0d", r, lat, NDIG); end
    endtask

    task automatic test_back_to_back();
        logic [M-1:0] q[$];
        logic [M-1:0] exp;
        int last, cyc, got, guard;
        last = -1; cyc = 0; got = 0;
        a = rand_m(); b = rand_m(); in_valid = 1'b1;
        while (got < 8 && cyc < 600) begin
            if (in_ready) q.push_back(gf_ref(a, b, M, K));
            if (out_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL b2b_unexpected got result %h want none", result);
                end else begin
                    exp = q.pop_front();
                    if (result !== exp) begin n_err++; $display("FAIL b2b_result[%0d] got %h want %h", got, result, exp); end
                end
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last !== NDIG + 2) begin n_err++; $display("FAIL b2b_period got %0d want %0d", cyc - last, NDIG + 2); end
                end
                last = cyc;
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            a = rand_m(); b = rand_m();
        end
        in_valid = 1'b0;
        n_cmp++; if (got !== 8) begin n_err++; $display("FAIL b2b_count got %0d want 8", got); end
        guard = 0;
        while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    endtask

    task automatic test_small();
        logic [SM-1:0] r, ia, ib, exp;
        int lat;
        run_small(7'b1000000, 7'b0000010, r, lat);
        n_cmp++; if (r !== 7'b0001001) begin n_err++; $display("FAIL small_x6_x got %b want 0001001", r); end
        n_cmp++; if (lat !== SNDIG) begin n_err++; $display("FAIL small_latency got %0d want %0d", lat, SNDIG); end
        for (int i = 0; i < 6; i++) begin
            ia = SM'($urandom); ib = SM'($urandom);
            exp = SM'(gf_ref(233'(ia), 233'(ib), SM, SK));
            run_small(ia, ib, r, lat);
            n_cmp++; if (r !== exp) begin n_err++; $display("FAIL small_rand[%0d] got %b want %b", i, r, exp); end
        end
    endtask

`ifdef GF2M_MUL_ACC_EN
    task automatic test_accumulate();
        logic [M-1:0] r, ia, ib, prev;
        int lat;
        acc = 1'b0;
        run_big(M'(1), M'(1), r, lat);
        acc = 1'b1;
        run_big(M'(2), M'(1), r, lat);
        n_cmp++; if (r !== M'(3)) begin n_err++; $display("FAIL acc_x_plus_1 got %h want 3", r); end
        n_cmp++; if (lat !== NDIG) begin n_err++; $display("FAIL acc_latency got %0d want %0d", lat, NDIG); end
        acc = 1'b0;
        run_big(M'(2), M'(1), r, lat);
        n_cmp++; if (r !== M'(2)) begin n_err++; $display("FAIL acc_overwrite got %h want 2", r); end
        prev = r;
        ia = rand_m(); ib = rand_m();
        acc = 1'b1;
        run_big(ia, ib, r, lat);
        n_cmp++; if (r !== (prev ^ gf_ref(ia, ib, M, K))) begin n_err++; $display("FAIL acc_rand got %h want %h", r, prev ^ gf_ref(ia, ib, M, K)); end
        acc = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b1; s_a = '0; s_b = '0;
`ifdef GF2M_MUL_ACC_EN
        acc = 1'b0; s_acc = 1'b0;
`endif
        test_reset();
        test_basic();
        test_fold();
        test_zero_ignore();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_small();
`ifdef GF2M_MUL_ACC_EN
        test_accumulate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
